gate_sweep_checker: RTL and testbench
=====================================

# gate_sweep_checker

Self-running stimulus generator and response checker for small combinational gate blocks: on `start` it walks every N-bit input vector into the gate under test and compares the gate's output with a selected reference function. It counts mismatches and records the first failing vector. It sits on both sides of the gate: `dut_in` feeds the gate's inputs, and `dut_y` consumes the gate's output. This lets exhaustive truth-table checks run in hardware or synthesizable benches without hand-written vector lists.

## Interface
- `N`, default 3: number of gate inputs (1..8).
- `SETTLE`, default 2: wait cycles between applying a vector and sampling `dut_y` (≥1).

- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a sweep; honoured only in IDLE or DONE.
- `op`  in  2: reference function, latched at start. 00 OR, 01 AND, 10 XOR, 11 NOR, all reduced over `dut_in`.
- `dut_y`  in  1: output of gate under test.
- `dut_in`  out  N: vector driven to gate inputs; bit 0 maps to the gate's last input (`c` for a 3-input gate).
- `busy`  out  1: sweep in progress.
- `done`  out  1: sweep complete; level, held until next start or reset.
- `pass`  out  1: `done` && `err_count`==0.
- `err_count`  out  N+1: number of mismatching vectors; cannot overflow because max is 2^N.
- `first_fail_vec`  out  N: lowest vector that mismatched.
- `first_fail_valid`  out  1: `first_fail_vec` holds a captured value.

## Operation
- FSM states: IDLE, WAIT, CHECK, DONE.
- **IDLE / DONE, `start`=1:**
  - Set `vec`=0, `err_count`=0, `first_fail_valid`=0, `first_fail_vec`=0.
  - Latch `op`, clear the settle counter, clear `done`/`pass`, go to WAIT.
- **IDLE / DONE, `start`=0:** stay; outputs hold.
- **WAIT:** count SETTLE cycles, then go to CHECK. `dut_in` = `vec` throughout.
- **CHECK:**
  - exp = f(op_latched, `vec`). If `dut_y` != exp, increment `err_count`.
  - On a mismatch with `first_fail_valid`=0, set `first_fail_vec`=`vec` and `first_fail_valid`=1.
  - If `vec` is all-ones, go to DONE. Otherwise increment `vec`, clear the settle counter, and go to WAIT.
- **DONE:** `done`=1, `pass` = (`err_count`==0). `dut_in` holds the all-ones vector.
- `busy`=1 exactly in WAIT and CHECK.
- `start` while busy is ignored and has no side effects.
- `dut_y` is treated as a settled level; it is not synchronised. X or Z on `dut_y` counts as a mismatch.
- Reset values, applied immediately and asynchronously, including mid-sweep:
  - state IDLE
  - `dut_in`=0, `busy`=0, `done`=0, `pass`=0
  - `err_count`=0, `first_fail_vec`=0, `first_fail_valid`=0
  - A sweep aborted by reset is not resumed.

## Timing
- Edge k samples `start`=1 in IDLE/DONE. From edge k: `dut_in`=0, `busy`=1, `done`=0.
- Vector v is driven from edge k+v·(SETTLE+1) and compared at edge k+(v+1)·(SETTLE+1).
- The `err_count`/`first_fail` update is visible after the CHECK edge, at the same edge where `dut_in` advances.
- After edge k+2^N·(SETTLE+1): `done`=1, `busy`=0, `pass` valid. Defaults give 24 cycles.
- Restart from DONE: `start` at edge j clears `done` from edge j; timing then repeats as above.
- `start` held high continuously causes back-to-back sweeps, with exactly one DONE cycle between them.

## Test plan
- **Correct OR gate:** N=3, SETTLE=2, `dut_y`=|`dut_in`, op=00, `start` pulse.
  - `done` rises exactly 24 cycles after the start edge.
  - `err_count`=0, `pass`=1, `first_fail_valid`=0.
  - `dut_in` steps 000→111, each vector held 3 cycles.
- **Stuck-at-0 gate:** `dut_y`=0, op=00.
  - `err_count`=7, `first_fail_vec`=001, `first_fail_valid`=1, `pass`=0.
- **Wrong function:** OR gate connected, op=01 (AND).
  - `err_count`=6 (vectors 001–110), `first_fail_vec`=001, `pass`=0.
- **Ignored start:** extra `start` pulses at cycles 5 and 12 of a sweep.
  - No effect: `done` still at cycle 24, same counts.
  - `op` changed mid-sweep also has no effect.
- **Reset mid-sweep:** `rst` at cycle 10 (asynchronous, between edges).
  - All outputs reach reset values before the next edge.
  - A subsequent start completes normally in 24 cycles.
- **Restart from DONE:** after the stuck-at-0 run, connect the correct gate and pulse `start`.
  - `done`/`err_count`/`first_fail_valid` clear at the start edge.
  - Final `err_count`=0, `pass`=1.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive truth-table sweeper for small combinational
// gates. Drives every N-bit vector onto dut_in, waits SETTLE cycles, then
// compares dut_y against a selected reduction function of the vector.
//
// Handshake: start is a level request sampled on each rising edge, but it is
// acted on only in IDLE or DONE. While busy it is ignored and has no side
// effects. done is a level that stays high until the next accepted start or
// reset. pass is meaningful only while done is high.
module gate_sweep_checker #(
  parameter int N      = 3,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         dut_y,
  output logic [N-1:0] dut_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail_vec,
  output logic         first_fail_valid,
  output logic [1:0]   state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Settle counter runs 0..SETTLE-1, so it never needs to hold SETTLE itself.
  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N-1:0]    VEC_LAST = '1;

  state_e        state_q, state_d;
  logic [N-1:0]  vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [N:0]    err_q, err_d;
  logic [N-1:0]  ffv_q, ffv_d;
  logic          ffval_q, ffval_d;

  logic          exp_bit;
  logic          mismatch;

  // Reference function of the current vector, chosen by the latched op.
  always_comb begin
    exp_bit = 1'b0;
    case (op_q)
      2'b00:   exp_bit = |vec_q;
      2'b01:   exp_bit = &vec_q;
      2'b10:   exp_bit = ^vec_q;
      default: exp_bit = ~(|vec_q);
    endcase
    // Case equality so an unknown gate output is reported as a mismatch.
    mismatch = (dut_y === exp_bit) ? 1'b0 : 1'b1;
  end

  // Next-state and datapath updates for the sweep FSM.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          ffv_d   = '0;
          ffval_d = 1'b0;
          op_d    = op;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + (N+1)'(1);
          if (!ffval_q) begin
            ffv_d   = vec_q;
            ffval_d = 1'b1;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + N'(1);
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous reset; an aborted sweep is simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      err_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    dut_in           = vec_q;
    busy             = (state_q == S_WAIT) || (state_q == S_CHECK);
    done             = (state_q == S_DONE);
    pass             = (state_q == S_DONE) && (err_q == '0);
    err_count        = err_q;
    first_fail_vec   = ffv_q;
    first_fail_valid = ffval_q;
    state_o          = state_q;
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: directed sweeps of gate_sweep_checker with a
// scoreboard of hand-computed sweep results.
module tb_gate_sweep_checker;

  localparam int N      = 3;
  localparam int SETTLE = 2;
  localparam int W      = 17;  // {err[3:0], ffv[2:0], ffval, pass, latency[7:0]}

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic         dut_y;
  logic [N-1:0] dut_in;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic [N-1:0] first_fail_vec;
  logic         first_fail_valid;
  logic [1:0]   state_o;

  logic [1:0]   gate_sel;
  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;

  gate_sweep_checker #(.N(N), .SETTLE(SETTLE)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .op               (op),
    .dut_y            (dut_y),
    .dut_in           (dut_in),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid),
    .state_o          (state_o)
  );

  // Clock and gate-under-test model.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (gate_sel)
      2'd0:    dut_y = |dut_in;
      2'd1:    dut_y = 1'b0;
      2'd2:    dut_y = ^dut_in;
      default: dut_y = &dut_in;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input int err, input int ffv, input int ffval,
                                      input int ps);
    return {4'(err), 3'(ffv), 1'(ffval), 1'(ps), 8'(24)};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dut_in"}, 32'(dut_in), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
    chk({tag, "_ffv"}, 32'(first_fail_vec), 0);
    chk({tag, "_ffvalid"}, 32'(first_fail_valid), 0);
  endtask

  // Queue the expected result, pulse start, and check the start-edge clears.
  task automatic start_sweep(input logic [1:0] o, input logic [W-1:0] e);
    exp_q.push_back(e);
    @(negedge clk);
    op    = o;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_done", 32'(done), 0);
    chk("start_err_clear", 32'(err_count), 0);
    chk("start_ffvalid_clear", 32'(first_fail_valid), 0);
    chk("start_dut_in", 32'(dut_in), 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_done timeout got done=%0b expected 1 at %0t", done, $time);
    end
  endtask

  // Monitor: checks vector stepping while busy and pops a result on each done rise.
  int           bcnt;
  logic         done_prev;
  logic [W-1:0] e_item;
  logic [W-1:0] got_item;
  initial begin
    bcnt      = 0;
    done_prev = 1'b0;
  end
  always @(negedge clk) begin
    if (!rst && busy) begin
      chk("dut_in_step", 32'(dut_in), 32'(bcnt / (SETTLE + 1)));
      bcnt++;
    end
    if (!rst && done && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got done=1 expected no pending sweep at %0t", $time);
      end else begin
        e_item   = exp_q.pop_front();
        got_item = {4'(err_count), first_fail_vec, first_fail_valid, pass, 8'(bcnt)};
        chk("sweep_result", 32'(got_item), 32'(e_item));
        chk("done_dut_in", 32'(dut_in), 7);
        chk("done_busy", 32'(busy), 0);
      end
    end
    if (rst || !busy) bcnt = 0;
    done_prev = done;
  end

  // Directed sequence.
  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    gate_sel = 2'd0;
    #1 rst = 1'b1;
    #1 chk_reset_vals("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Correct OR gate.
    gate_sel = 2'd0;
    start_sweep(2'b00, mk(0, 0, 0, 1));
    wait_done();

    // Stuck-at-0 gate.
    @(negedge clk);
    gate_sel = 2'd1;
    start_sweep(2'b00, mk(7, 1, 1, 0));
    wait_done();

    // Restart from DONE with the correct gate.
    @(negedge clk);
    gate_sel = 2'd0;
    start_sweep(2'b00, mk(0, 0, 0, 1));
    wait_done();

    // Wrong function: OR gate checked against AND.
    @(negedge clk);
    start_sweep(2'b01, mk(6, 1, 1, 0));
    wait_done();

    // OR gate checked against NOR: every vector fails, count reaches 2^N.
    @(negedge clk);
    start_sweep(2'b11, mk(8, 0, 1, 0));
    wait_done();

    // Correct XOR gate.
    @(negedge clk);
    gate_sel = 2'd2;
    start_sweep(2'b10, mk(0, 0, 0, 1));
    wait_done();

    // Correct AND gate.
    @(negedge clk);
    gate_sel = 2'd3;
    start_sweep(2'b01, mk(0, 0, 0, 1));
    wait_done();

    // Start pulses and op changes during a sweep are ignored.
    @(negedge clk);
    gate_sel = 2'd0;
    start_sweep(2'b00, mk(0, 0, 0, 1));
    repeat (3) @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    op    = 2'b11;
    @(negedge clk);
    start = 1'b0;
    op    = 2'b00;
    wait_done();

    // Asynchronous reset mid-sweep, then a normal sweep.
    @(negedge clk);
    start_sweep(2'b00, mk(0, 0, 0, 1));
    repeat (8) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_vals("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    start_sweep(2'b00, mk(0, 0, 0, 1));
    wait_done();

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
